branch_resolve: RTL and testbench
=================================

# branch_resolve

Resolves branches in ID against the predictions made at fetch and closes the predictor training loop. It holds the fetch-stage prediction metadata (PC, taken bit, PHT index, BTB target) in a small FIFO until the matching instruction reaches ID. It then compares the prediction with the real outcome and drives the registered feedback bundle back into the PC stage: branch/jump/taken/miss, last PHT index, instruction PC, and target. On a mispredict it also supplies the redirect address and a flush.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- GHR_WIDTH, 10, PHT index width
- DEPTH, 4, prediction FIFO entries (power of two, ≥2)
- FALLTHRU, 8, byte offset of the not-taken path from the branch PC (branch plus delay slot)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pred_valid  in  1  PC stage issued a fetch this cycle
- pred_pc  in  ADDR_WIDTH  fetched PC
- pred_taken  in  1  predictor said taken
- pred_index  in  GHR_WIDTH  PHT index used
- pred_target  in  ADDR_WIDTH  BTB target used when taken
- pred_full  out  1  FIFO full; PC stage must hold
- id_valid  in  1  ID consumes one instruction this cycle
- id_is_branch  in  1  conditional branch
- id_is_jump  in  1  unconditional direct jump (j/jal)
- id_cond  in  1  branch condition true
- id_target  in  ADDR_WIDTH  computed target
- is_branch_out, is_jump_out, is_taken_out, is_miss_out  out  1  feedback to PC stage
- last_pht_index  out  GHR_WIDTH  index of the resolved entry
- inst_pc  out  ADDR_WIDTH  PC of the resolved instruction
- target_out  out  ADDR_WIDTH  actual branch target (BTB training)
- redirect_pc  out  ADDR_WIDTH  correct next fetch PC on miss
- flush_out  out  1  squash the wrong path
- underflow_err  out  1  id_valid with empty FIFO
- branch_cnt, miss_cnt  out  32  statistics

## Operation
- Push on pred_valid && !full: store {pc, taken, index, target} at the write pointer.
- Pop on id_valid && !empty: read the head entry.
- Same-cycle push and pop when full is legal; the count is unchanged.
- Resolution on pop, for a control instruction (id_is_branch || id_is_jump):
  - actual_taken = id_is_jump || id_cond.
  - miss = (actual_taken != entry.taken) || (actual_taken && entry.target != id_target).
- Non-control pop with entry.taken = 1 (BTB false hit):
  - miss = 1; is_branch_out = 0.
  - redirect_pc = entry.pc + FALLTHRU.
- Redirect address on miss: id_target if actual_taken, else entry.pc + FALLTHRU (modulo 2^ADDR_WIDTH).
- On miss: flush_out = 1 and the FIFO is emptied (pointers reset). All queued entries are wrong-path.
- Priority within one cycle: flush beats push, so a push in a miss cycle is dropped. Reset beats everything.
- Underflow: id_valid while empty gives:
  - underflow_err pulses.
  - The entry is treated as {pc=0, taken=0, index=0, target=0}.
  - Resolution proceeds with inst_pc = 0.
- Pointers are DEPTH-wrapping, with an extra bit for full/empty distinction.

## Timing
- Inputs are sampled at posedge. All feedback outputs, redirect_pc, flush_out and underflow_err are registered, one cycle after the pop. They are single-cycle pulses; data holds its value until the next pop.
- When no pop occurs: is_branch_out, is_jump_out, is_taken_out, is_miss_out and flush_out are 0.
- pred_full is combinational from the pointers and does not depend on the same-cycle pop.
- Reset values:
  - All outputs are 0 and the FIFO is empty.
  - pred_full is 0.
  - Counters are 0.
- Reset asserted mid-operation discards all entries the next cycle.

## Configuration
- BRANCH_STAT_EN defined:
  - branch_cnt increments on every resolved control pop.
  - miss_cnt increments on every miss.
  - Both are 32-bit and wrap.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Predicted-taken branch: push pc 0x100, taken=1, target 0x200; pop with id_is_branch=1, id_cond=1, id_target 0x200 -> next cycle is_branch_out=1, is_taken_out=1, is_miss_out=0, flush_out=0.
- Direction miss: push pc 0x100, taken=0; pop with cond=1, target 0x300 -> is_miss_out=1, redirect_pc=0x300, flush_out=1, FIFO empty.
- Not-taken miss: push pc 0x100, taken=1; pop with cond=0 -> redirect_pc=0x108, is_taken_out=0.
- Full boundary: push 4 entries -> pred_full=1. A 5th push with no pop is ignored. Push+pop in the same cycle keeps pred_full=1 and preserves FIFO order.
- Miss and push in the same cycle: the push is dropped and the FIFO is empty afterwards. id_valid next cycle -> underflow_err=1.
- BRANCH_STAT_EN: 3 branches with 1 miss -> branch_cnt=3, miss_cnt=1. rst low -> both 0.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution in ID: prediction FIFO, miss detection and PC-stage feedback.
// Optional statistics counters are built when BRANCH_STAT_EN is defined.
module branch_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 10,
    parameter int DEPTH      = 4,
    parameter int FALLTHRU   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  pred_taken,
    input  logic [GHR_WIDTH-1:0]  pred_index,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  pred_full,
    input  logic                  id_valid,
    input  logic                  id_is_branch,
    input  logic                  id_is_jump,
    input  logic                  id_cond,
    input  logic [ADDR_WIDTH-1:0] id_target,
    output logic                  is_branch_out,
    output logic                  is_jump_out,
    output logic                  is_taken_out,
    output logic                  is_miss_out,
    output logic [GHR_WIDTH-1:0]  last_pht_index,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [ADDR_WIDTH-1:0] target_out,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_out,
    output logic                  underflow_err,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] FT = ADDR_WIDTH'(FALLTHRU);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  taken;
        logic [GHR_WIDTH-1:0]  index;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [PW:0]           wr_q, wr_d, rd_q, rd_d;
    logic                  empty, full, push, pop;
    logic                  ctrl, act_taken, miss;
    entry_t                head;
    logic [ADDR_WIDTH-1:0] redir;

    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[PW] != rd_q[PW]) &&
                (wr_q[PW-1:0] == rd_q[PW-1:0]);
        pop   = id_valid && !empty;
        head  = empty ? '0 : mem_q[rd_q[PW-1:0]];
        ctrl      = id_is_branch || id_is_jump;
        act_taken = id_is_jump || id_cond;
        miss = 1'b0;
        if (id_valid) begin
            if (ctrl)
                miss = (act_taken != head.taken) ||
                       (act_taken && (head.target != id_target));
            else
                miss = head.taken;
        end
        // A pop frees a slot in the same cycle, so a full FIFO may still accept
        push  = pred_valid && (!full || pop) && !miss;
        redir = (ctrl && act_taken) ? id_target : head.pc + FT;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (miss) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_ONE;
            if (pop)  rd_d = rd_q + PTR_ONE;
        end
    end

    assign pred_full = full;

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q[PW-1:0]] <= '{pred_pc, pred_taken, pred_index, pred_target};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q           <= '0;
            rd_q           <= '0;
            is_branch_out  <= 1'b0;
            is_jump_out    <= 1'b0;
            is_taken_out   <= 1'b0;
            is_miss_out    <= 1'b0;
            flush_out      <= 1'b0;
            underflow_err  <= 1'b0;
            last_pht_index <= '0;
            inst_pc        <= '0;
            target_out     <= '0;
            redirect_pc    <= '0;
        end else begin
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            is_branch_out <= id_valid && id_is_branch;
            is_jump_out   <= id_valid && id_is_jump;
            is_taken_out  <= id_valid && ctrl && act_taken;
            is_miss_out   <= miss;
            flush_out     <= miss;
            underflow_err <= id_valid && empty;
            if (id_valid) begin
                last_pht_index <= head.index;
                inst_pc        <= head.pc;
                target_out     <= id_target;
                redirect_pc    <= redir;
            end
        end
    end

`ifdef BRANCH_STAT_EN
    logic [31:0] bcnt_q, mcnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (id_valid && ctrl) bcnt_q <= bcnt_q + 32'd1;
            if (miss)             mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign branch_cnt = bcnt_q;
    assign miss_cnt   = mcnt_q;
`else
    assign branch_cnt = '0;
    assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve.
// Table rows are one cycle each; hand sequences cover reset and counters.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [9:0]  pred_index = '0;
    logic [31:0] pred_target = '0;
    logic        pred_full;
    logic        id_valid = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_is_jump = 1'b0;
    logic        id_cond = 1'b0;
    logic [31:0] id_target = '0;
    logic        is_branch_out, is_jump_out, is_taken_out, is_miss_out;
    logic [9:0]  last_pht_index;
    logic [31:0] inst_pc, target_out, redirect_pc;
    logic        flush_out, underflow_err;
    logic [31:0] branch_cnt, miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_index(pred_index),
        .pred_target(pred_target), .pred_full(pred_full),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_is_jump(id_is_jump), .id_cond(id_cond),
        .id_target(id_target),
        .is_branch_out(is_branch_out), .is_jump_out(is_jump_out),
        .is_taken_out(is_taken_out), .is_miss_out(is_miss_out),
        .last_pht_index(last_pht_index), .inst_pc(inst_pc),
        .target_out(target_out), .redirect_pc(redirect_pc),
        .flush_out(flush_out), .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [9:0]  pidx;
        logic [31:0] ptgt;
        logic        idv, br, jp, cond;
        logic [31:0] itgt;
        logic        e_full, e_br, e_jp, e_tk, e_miss, e_uf, chk;
        logic [9:0]  e_idx;
        logic [31:0] e_pc, e_tgt, e_redir;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t idle(logic full);
        vec_t v;
        v = '{default: '0};
        v.e_full = full;
        return v;
    endfunction

    function automatic vec_t P(logic [31:0] pc, logic t, logic [9:0] ix,
                               logic [31:0] tg, logic full);
        vec_t v;
        v = idle(full);
        v.pv = 1'b1; v.ppc = pc; v.pt = t; v.pidx = ix; v.ptgt = tg;
        return v;
    endfunction

    function automatic vec_t R(logic br, logic jp, logic cond,
                               logic [31:0] it, logic tk, logic ms,
                               logic [9:0] ix, logic [31:0] pc,
                               logic [31:0] rd, logic full, logic uf);
        vec_t v;
        v = idle(full);
        v.idv = 1'b1; v.br = br; v.jp = jp; v.cond = cond; v.itgt = it;
        v.e_br = br; v.e_jp = jp; v.e_tk = tk; v.e_miss = ms;
        v.e_uf = uf; v.chk = 1'b1; v.e_idx = ix; v.e_pc = pc;
        v.e_tgt = it; v.e_redir = rd;
        return v;
    endfunction

    function automatic vec_t PR(vec_t a, logic [31:0] pc, logic t,
                                logic [9:0] ix, logic [31:0] tg);
        vec_t v;
        v = a;
        v.pv = 1'b1; v.ppc = pc; v.pt = t; v.pidx = ix; v.ptgt = tg;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        pred_valid = v.pv; pred_pc = v.ppc; pred_taken = v.pt;
        pred_index = v.pidx; pred_target = v.ptgt;
        id_valid = v.idv; id_is_branch = v.br; id_is_jump = v.jp;
        id_cond = v.cond; id_target = v.itgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(string nm, vec_t v);
        chk({nm, ".full"}, 32'(pred_full), 32'(v.e_full));
        chk({nm, ".br"}, 32'(is_branch_out), 32'(v.e_br));
        chk({nm, ".jp"}, 32'(is_jump_out), 32'(v.e_jp));
        chk({nm, ".tk"}, 32'(is_taken_out), 32'(v.e_tk));
        chk({nm, ".miss"}, 32'(is_miss_out), 32'(v.e_miss));
        chk({nm, ".flush"}, 32'(flush_out), 32'(v.e_miss));
        chk({nm, ".uf"}, 32'(underflow_err), 32'(v.e_uf));
        if (v.chk) begin
            chk({nm, ".idx"}, 32'(last_pht_index), 32'(v.e_idx));
            chk({nm, ".pc"}, inst_pc, v.e_pc);
            chk({nm, ".tgt"}, target_out, v.e_tgt);
        end
        if (v.e_miss)
            chk({nm, ".redir"}, redirect_pc, v.e_redir);
    endtask

    initial begin
        // predicted-taken hit, direction miss, not-taken miss
        vq.push_back(P(32'h100, 1, 10'd5, 32'h200, 0));
        vq.push_back(R(1, 0, 1, 32'h200, 1, 0, 10'd5, 32'h100, 32'h0, 0, 0));
        vq.push_back(P(32'h100, 0, 10'd7, 32'h0, 0));
        vq.push_back(R(1, 0, 1, 32'h300, 1, 1, 10'd7, 32'h100, 32'h300, 0, 0));
        vq.push_back(P(32'h100, 1, 10'd1, 32'h200, 0));
        vq.push_back(R(1, 0, 0, 32'h200, 0, 1, 10'd1, 32'h100, 32'h108, 0, 0));
        vq.push_back(idle(0));
        // jump with wrong BTB target, BTB false hit, plain instruction
        vq.push_back(P(32'h400, 1, 10'd2, 32'h500, 0));
        vq.push_back(R(0, 1, 0, 32'h600, 1, 1, 10'd2, 32'h400, 32'h600, 0, 0));
        vq.push_back(P(32'h700, 1, 10'd3, 32'h800, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 1, 10'd3, 32'h700, 32'h708, 0, 0));
        vq.push_back(P(32'h710, 0, 10'd4, 32'h0, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd4, 32'h710, 32'h0, 0, 0));
        // full boundary, dropped 5th push, push+pop while full, order
        vq.push_back(P(32'h1000, 0, 10'd1, 32'h0, 0));
        vq.push_back(P(32'h1004, 0, 10'd2, 32'h0, 0));
        vq.push_back(P(32'h1008, 0, 10'd3, 32'h0, 0));
        vq.push_back(P(32'h100C, 0, 10'd4, 32'h0, 1));
        vq.push_back(P(32'h1010, 0, 10'd8, 32'h0, 1));
        vq.push_back(PR(R(0, 0, 0, 32'h0, 0, 0, 10'd1, 32'h1000, 32'h0, 1, 0),
                        32'h1014, 0, 10'd6, 32'h0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd2, 32'h1004, 32'h0, 0, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd3, 32'h1008, 32'h0, 0, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd4, 32'h100C, 32'h0, 0, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd6, 32'h1014, 32'h0, 0, 0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd0, 32'h0, 32'h0, 0, 1));
        // miss with a same-cycle push: push dropped, next pop underflows
        vq.push_back(P(32'h2000, 0, 10'd9, 32'h0, 0));
        vq.push_back(PR(R(1, 0, 1, 32'h2100, 1, 1, 10'd9, 32'h2000, 32'h2100, 0, 0),
                        32'h3000, 0, 10'd10, 32'h0));
        vq.push_back(R(0, 0, 0, 32'h0, 0, 0, 10'd0, 32'h0, 32'h0, 0, 1));
        // underflow on a taken branch: zero entry mispredicts
        vq.push_back(R(1, 0, 1, 32'h50, 1, 1, 10'd0, 32'h0, 32'h50, 0, 1));
        vq.push_back(idle(0));

        rst = 1'b0;
        tick();
        tick();
        check_row("reset", idle(0));
        chk("reset.pc", inst_pc, 32'h0);
        chk("reset.redir", redirect_pc, 32'h0);
        chk("reset.bcnt", branch_cnt, 32'h0);
        chk("reset.mcnt", miss_cnt, 32'h0);
        rst = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i]);
            tick();
            check_row($sformatf("v%0d", i), vq[i]);
        end

        // reset mid-operation beats a would-be miss and empties the FIFO
        drive(P(32'h10, 0, 10'd1, 32'h0, 0));
        tick();
        drive(P(32'h20, 0, 10'd2, 32'h0, 0));
        tick();
        drive(R(1, 0, 1, 32'h99, 0, 0, 10'd0, 32'h0, 32'h0, 0, 0));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_row("midrst", idle(0));
        chk("midrst.pc", inst_pc, 32'h0);
        chk("midrst.bcnt", branch_cnt, 32'h0);
        chk("midrst.mcnt", miss_cnt, 32'h0);
        drive(R(0, 0, 0, 32'h0, 0, 0, 10'd0, 32'h0, 32'h0, 0, 1));
        tick();
        check_row("midrst.uf", R(0, 0, 0, 32'h0, 0, 0, 10'd0, 32'h0, 32'h0, 0, 1));

        // three branches, one miss
        drive(P(32'h100, 1, 10'd1, 32'h200, 0));
        tick();
        drive(R(1, 0, 1, 32'h200, 1, 0, 10'd1, 32'h100, 32'h0, 0, 0));
        tick();
        drive(P(32'h110, 0, 10'd2, 32'h0, 0));
        tick();
        drive(R(1, 0, 0, 32'h300, 0, 0, 10'd2, 32'h110, 32'h0, 0, 0));
        tick();
        drive(P(32'h120, 0, 10'd3, 32'h0, 0));
        tick();
        drive(R(1, 0, 1, 32'h400, 1, 1, 10'd3, 32'h120, 32'h400, 0, 0));
        tick();
        check_row("cnt.miss", R(1, 0, 1, 32'h400, 1, 1, 10'd3, 32'h120, 32'h400, 0, 0));
        drive(idle(0));
        tick();
`ifdef BRANCH_STAT_EN
        chk("cnt.branch", branch_cnt, 32'd3);
        chk("cnt.miss_cnt", miss_cnt, 32'd1);
`else
        chk("cnt.branch", branch_cnt, 32'd0);
        chk("cnt.miss_cnt", miss_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("cnt.rst_b", branch_cnt, 32'd0);
        chk("cnt.rst_m", miss_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
